// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Step counter width; never narrower than one bit, even for N = 2.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One add-shift step: conditionally adds the multiplicand, shifted to the step position, into acc.
module seq_mult_step #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   mag_m,
    input  logic           q_bit,
    input  logic [CW-1:0]  step,
    output logic [2*N-1:0] acc_next
);

    logic [2*N-1:0] addend;

    // Magnitudes never exceed 2^(N-1) signed, so the 2N-bit sum cannot carry out.
    assign addend   = {{N{1'b0}}, mag_m} << step;
    assign acc_next = q_bit ? (acc + addend) : acc;

endmodule

// File: rtl/seq_multiplier_n.sv
// N x N shift-add multiplier, one partial-product row per clock, signed or unsigned per operation.
module seq_multiplier_n
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   q,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int CW = cnt_w(N);

    mult_state_t    state_reg, state_next;
    logic [N-1:0]   mag_m_reg, mag_q_reg;
    logic           neg_reg;
    logic [2*N-1:0] acc_reg, acc_next, p_reg;
    logic [CW-1:0]  cnt_reg;
    logic           accept, is_last;

    assign accept  = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign is_last = (cnt_reg == CW'(N - 1));

    seq_mult_step #(
        .N  (N),
        .CW (CW)
    ) u_step (
        .acc      (acc_reg),
        .mag_m    (mag_m_reg),
        .q_bit    (mag_q_reg[cnt_reg]),
        .step     (cnt_reg),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (is_last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == RUN);
        done = (state_reg == DONE);
    end

    // Operands are reduced to magnitudes at load; the sign is reapplied once at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_m_reg <= '0;
            mag_q_reg <= '0;
            neg_reg   <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            p_reg     <= '0;
        end else if (accept) begin
            mag_m_reg <= (is_signed && m[N-1]) ? (~m + 1'b1) : m;
            mag_q_reg <= (is_signed && q[N-1]) ? (~q + 1'b1) : q;
            neg_reg   <= is_signed && (m[N-1] ^ q[N-1]);
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (is_last)
                p_reg <= neg_reg ? (~acc_next + 1'b1) : acc_next;
        end
    end

    assign P = p_reg;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed and randomised checks of seq_multiplier_n at N=4 and N=8.
module tb_seq_multiplier_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, sgn4 = 1'b0;
    logic [3:0] m4 = '0, q4 = '0;
    logic       busy4, done4;
    logic [7:0] p4;
    logic       start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0] m8 = '0, q8 = '0;
    logic       busy8, done8;
    logic [15:0] p8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_multiplier_n #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .is_signed(sgn4),
        .m(m4), .q(q4), .busy(busy4), .done(done4), .P(p4)
    );

    seq_multiplier_n #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
        .m(m8), .q(q8), .busy(busy8), .done(done8), .P(p8)
    );

    typedef struct {
        int          n;
        bit          sgn;
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] p;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {busy, done, P} of the selected instance
    function automatic logic [65:0] probe(input int n);
        if (n == 4) return {busy4, done4, 56'd0, p4};
        return {busy8, done8, 48'd0, p8};
    endfunction

    function automatic logic [63:0] ref_prod(input int n, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, pr;
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        sa = longint'(64'(a) & mask);
        sb = longint'(64'(b) & mask);
        if (sgn && a[n-1]) sa = sa - (longint'(1) << n);
        if (sgn && b[n-1]) sb = sb - (longint'(1) << n);
        pr = sa * sb;
        return 64'(pr) & ((64'd1 << (2 * n)) - 64'd1);
    endfunction

    task automatic drive(input int n, input bit st, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b);
        if (n == 4) begin
            start4 = st; sgn4 = sgn; m4 = a[3:0]; q4 = b[3:0];
        end else begin
            start8 = st; sgn8 = sgn; m8 = a[7:0]; q8 = b[7:0];
        end
    endtask

    // One complete operation with latency, busy-length, exclusivity and hold checks.
    task automatic run_op(input int n, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input string tag);
        logic [65:0] s;
        logic [63:0] p_done;
        int cyc, bcnt;
        bit overlap;
        @(negedge clk);
        drive(n, 1'b1, sgn, a, b);
        @(negedge clk);
        drive(n, 1'b0, sgn, 32'hDEAD_BEEF, 32'h1234_5678);
        cyc = 1; bcnt = 0; overlap = 0;
        s = probe(n);
        while (!s[64] && cyc < 100) begin
            if (s[65]) bcnt++;
            @(negedge clk);
            cyc++;
            s = probe(n);
        end
        if (s[65] && s[64]) overlap = 1;
        check({tag, " done_latency"}, 64'(cyc), 64'(n + 1));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(n));
        check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
        p_done = s[63:0];
        check({tag, " P"}, p_done, exp);
        @(negedge clk);
        s = probe(n);
        check({tag, " done_single_cycle"}, 64'(s[64]), 64'd0);
        check({tag, " P_hold"}, s[63:0], exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4, 1'b0, 32'hF,  32'hF,  64'hE1};
        vecs[1]  = '{4, 1'b1, 32'h8,  32'h8,  64'h40};
        vecs[2]  = '{4, 1'b1, 32'hD,  32'h5,  64'hF1};
        vecs[3]  = '{4, 1'b0, 32'h0,  32'h0,  64'h00};
        vecs[4]  = '{4, 1'b1, 32'h7,  32'h8,  64'hC8};
        vecs[5]  = '{4, 1'b0, 32'h3,  32'h5,  64'h0F};
        vecs[6]  = '{4, 1'b1, 32'hF,  32'hF,  64'h01};
        vecs[7]  = '{8, 1'b1, 32'h80, 32'h01, 64'hFF80};
        vecs[8]  = '{8, 1'b0, 32'h00, 32'hFF, 64'h0000};
        vecs[9]  = '{8, 1'b0, 32'hFF, 32'hFF, 64'hFE01};
        vecs[10] = '{8, 1'b1, 32'h80, 32'h80, 64'h4000};
        vecs[11] = '{8, 1'b1, 32'h7F, 32'h81, 64'hC0FF};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy4", 64'(busy4), 64'd0);
        check("reset done4", 64'(done4), 64'd0);
        check("reset P4",    64'(p4),    64'd0);
        check("reset P8",    64'(p8),    64'd0);

        for (int i = 0; i < 12; i++) begin
            $display("vec %0d: N=%0d signed=%0d m=%0h q=%0h expect P=%0h",
                     i, vecs[i].n, vecs[i].sgn, vecs[i].m, vecs[i].q, vecs[i].p);
            run_op(vecs[i].n, vecs[i].sgn, vecs[i].m, vecs[i].q, vecs[i].p, $sformatf("vec%0d", i));
        end

        // start held high: operands scrambled during RUN, next operands presented in each done cycle
        begin
            logic [31:0] bm [4] = '{32'hF, 32'hD, 32'h8, 32'h6};
            logic [31:0] bq [4] = '{32'hF, 32'h5, 32'h8, 32'h3};
            bit          bs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
            int idx = 0, cyc = 0, last = 0;
            @(negedge clk);
            drive(4, 1'b1, bs[0], bm[0], bq[0]);
            while (idx < 4 && cyc < 60) begin
                @(negedge clk);
                cyc++;
                check("b2b busy_done_overlap", 64'(busy4 & done4), 64'd0);
                if (done4) begin
                    check($sformatf("b2b op%0d P", idx), 64'(p4),
                          ref_prod(4, bs[idx], bm[idx], bq[idx]));
                    check($sformatf("b2b op%0d gap", idx), 64'(cyc - last), 64'd5);
                    $display("b2b op%0d: done at cycle %0d P=%0h", idx, cyc, p4);
                    last = cyc;
                    idx++;
                    if (idx < 4) drive(4, 1'b1, bs[idx], bm[idx], bq[idx]);
                    else         drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
                end else begin
                    drive(4, 1'b1, ~sgn4, $urandom, $urandom);
                end
            end
            check("b2b ops_completed", 64'(idx), 64'd4);
            drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
            repeat (2) @(negedge clk);
        end

        // reset in the second RUN cycle aborts the operation
        begin
            bit saw_done = 0;
            @(negedge clk);
            drive(4, 1'b1, 1'b0, 32'hF, 32'hF);
            @(negedge clk);
            drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort busy", 64'(busy4), 64'd0);
            check("abort done", 64'(done4), 64'd0);
            check("abort P",    64'(p4),    64'd0);
            repeat (8) begin
                @(negedge clk);
                if (done4) saw_done = 1;
            end
            check("abort no_done", 64'(saw_done), 64'd0);
            $display("abort: busy=%0d done=%0d P=%0h", busy4, done4, p4);
        end

        for (int i = 0; i < 300; i++) begin
            bit          sg = i[0];
            logic [31:0] a = $urandom, b = $urandom;
            logic [63:0] e = ref_prod(8, sg, a, b);
            $display("rand %0d: signed=%0d m=%0h q=%0h expect P=%0h", i, sg, a[7:0], b[7:0], e);
            run_op(8, sg, a, b, e, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
